// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch program counter sequencer with redirect, stall, halt and retire count
module pc_sequencer #(
  parameter int unsigned           PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
  parameter logic [PC_WIDTH-1:0]   PC_LIMIT  = '0,
  parameter int unsigned           CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 stall_i,
  input  logic                 jmp_i,
  input  logic [PC_WIDTH-1:0]  jmp_target_i,
  input  logic                 br_taken_i,
  input  logic [PC_WIDTH-1:0]  br_offset_i,
  input  logic                 halt_req_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic                 pc_valid_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] retired_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STALL,
    S_HALT
  } state_e;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [PC_WIDTH-1:0]  next_pc;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 over_limit;

  // Candidate next address (jmp beats br_taken) and saturating retire increment
  always_comb begin
    next_pc    = pc_q + PC_WIDTH'(1);
    over_limit = 1'b0;
    cnt_inc    = cnt_q;
    if (jmp_i) begin
      next_pc = jmp_target_i;
    end else if (br_taken_i) begin
      next_pc = pc_q + PC_WIDTH'(1) + br_offset_i;
    end
    if ((PC_LIMIT != '0) && (next_pc >= PC_LIMIT)) begin
      over_limit = 1'b1;
    end
    if (!(&cnt_q)) begin
      cnt_inc = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Next-state logic; RUN and STALL share the same priority chain
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN, S_STALL: begin
        if (halt_req_i) begin
          state_d = S_HALT;
        end else if (!en_i) begin
          state_d = S_IDLE;
        end else if (stall_i) begin
          state_d = S_STALL;
        end else begin
          // Only an address presented from RUN counts as consumed
          if (state_q == S_RUN) begin
            cnt_d = cnt_inc;
          end
          if (over_limit) begin
            state_d = S_HALT;
          end else begin
            state_d = S_RUN;
            pc_d    = next_pc;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pc and counter registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_valid_o      = (state_q == S_RUN) || (state_q == S_STALL);
  assign halted_o        = (state_q == S_HALT);
  assign retired_count_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, stall, jmp, br, halt;
  logic [31:0] jt, bo;

  logic [31:0] pc_n, cnt_n, pc_l, cnt_l;
  logic        v_n, h_n, v_l, h_l;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'd0), .PC_LIMIT(32'd0), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .stall_i(stall), .jmp_i(jmp),
    .jmp_target_i(jt), .br_taken_i(br), .br_offset_i(bo), .halt_req_i(halt),
    .pc_o(pc_n), .pc_valid_o(v_n), .halted_o(h_n), .retired_count_o(cnt_n)
  );

  pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'd0), .PC_LIMIT(32'd10), .CNT_WIDTH(32)) dut_lim (
    .clk_i(clk), .rst_i(rst), .en_i(en), .stall_i(stall), .jmp_i(jmp),
    .jmp_target_i(jt), .br_taken_i(br), .br_offset_i(bo), .halt_req_i(halt),
    .pc_o(pc_l), .pc_valid_o(v_l), .halted_o(h_l), .retired_count_o(cnt_l)
  );

  typedef struct {
    logic        sel;
    logic [31:0] pc;
    logic        v;
    logic        h;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   slot     = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s slot %0d: got %h expected %h", name, slot, act, exp);
  endtask

  // Monitor: pops one expectation per cycle and compares against the selected instance
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel) begin
        cmp("lim_pc", pc_l, e.pc);
        cmp("lim_valid", 32'(v_l), 32'(e.v));
        cmp("lim_halted", 32'(h_l), 32'(e.h));
        cmp("lim_count", cnt_l, e.cnt);
      end else begin
        cmp("pc", pc_n, e.pc);
        cmp("valid", 32'(v_n), 32'(e.v));
        cmp("halted", 32'(h_n), 32'(e.h));
        cmp("count", cnt_n, e.cnt);
      end
      slot++;
    end
  end

  task automatic wait_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input logic sel, input logic [31:0] p, input logic v, input logic h,
                     input logic [31:0] c);
    exp_t e;
    e.sel = sel; e.pc = p; e.v = v; e.h = h; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic sel, input logic [31:0] p, input logic v, input logic h,
                     input logic [31:0] c);
    wait_slot();
    chk(sel, p, v, h, c);
  endtask

  // Reset asserted between edges: outputs must clear before the next edge
  task automatic do_reset(input logic sel);
    wait_slot();
    rst = 1'b1; en = 1'b0; stall = 1'b0; jmp = 1'b0; br = 1'b0; halt = 1'b0;
    jt = '0; bo = '0;
    chk(sel, 32'd0, 1'b0, 1'b0, 32'd0);
    wait_slot();
    chk(sel, 32'd0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0; en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; stall = 1'b0; jmp = 1'b0; br = 1'b0; halt = 1'b0;
    jt = '0; bo = '0;

    // Limit of 10: pc 0..9 then halt with pc 9 and 10 retired
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0, 32'(i));
    cyc(1'b1, 32'd9, 1'b0, 1'b1, 32'd10);
    cyc(1'b1, 32'd9, 1'b0, 1'b1, 32'd10);

    // Relative branches, then disable/re-enable holding pc
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'(i), 1'b1, 1'b0, 32'(i));
    br = 1'b1; bo = 32'hFFFF_FFFD;
    cyc(1'b0, 32'd2, 1'b1, 1'b0, 32'd5);
    br = 1'b0;
    cyc(1'b0, 32'd3, 1'b1, 1'b0, 32'd6);
    cyc(1'b0, 32'd4, 1'b1, 1'b0, 32'd7);
    cyc(1'b0, 32'd5, 1'b1, 1'b0, 32'd8);
    br = 1'b1; bo = 32'd2;
    cyc(1'b0, 32'd8, 1'b1, 1'b0, 32'd9);
    br = 1'b0;
    cyc(1'b0, 32'd9, 1'b1, 1'b0, 32'd10);
    en = 1'b0;
    cyc(1'b0, 32'd9, 1'b0, 1'b0, 32'd10);
    en = 1'b1;
    cyc(1'b0, 32'd9, 1'b1, 1'b0, 32'd10);
    cyc(1'b0, 32'd10, 1'b1, 1'b0, 32'd11);

    // jmp and br_taken together: jmp wins
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'(i), 1'b1, 1'b0, 32'(i));
    jmp = 1'b1; jt = 32'h40; br = 1'b1; bo = 32'd5;
    cyc(1'b0, 32'h40, 1'b1, 1'b0, 32'd4);
    jmp = 1'b0; br = 1'b0;
    cyc(1'b0, 32'h41, 1'b1, 1'b0, 32'd5);

    // Stall at pc 6 ignores jmp, count frozen; resume applies redirect
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'(i), 1'b1, 1'b0, 32'(i));
    stall = 1'b1; jmp = 1'b1; jt = 32'h80;
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd6, 1'b1, 1'b0, 32'd6);
    stall = 1'b0; jmp = 1'b0;
    cyc(1'b0, 32'd7, 1'b1, 1'b0, 32'd6);
    cyc(1'b0, 32'd8, 1'b1, 1'b0, 32'd7);
    stall = 1'b1;
    cyc(1'b0, 32'd8, 1'b1, 1'b0, 32'd7);
    stall = 1'b0; jmp = 1'b1; jt = 32'h20;
    cyc(1'b0, 32'h20, 1'b1, 1'b0, 32'd7);
    jmp = 1'b0;
    cyc(1'b0, 32'h21, 1'b1, 1'b0, 32'd8);

    // Wrap at all-ones, negative offset wrap, then async reset mid-run at pc 5
    do_reset(1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    jmp = 1'b1; jt = 32'hFFFF_FFFE;
    cyc(1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'd1);
    jmp = 1'b0;
    cyc(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd2);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd3);
    cyc(1'b0, 32'd1, 1'b1, 1'b0, 32'd4);
    br = 1'b1; bo = 32'hFFFF_FFFD;
    cyc(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd5);
    br = 1'b0;
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd6);
    for (int i = 1; i < 6; i++) cyc(1'b0, 32'(i), 1'b1, 1'b0, 32'(6 + i));
    do_reset(1'b0);

    // halt_req at pc 2; later activity leaves everything frozen
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'(i), 1'b1, 1'b0, 32'(i));
    halt = 1'b1;
    cyc(1'b0, 32'd2, 1'b0, 1'b1, 32'd2);
    halt = 1'b0; en = 1'b0;
    cyc(1'b0, 32'd2, 1'b0, 1'b1, 32'd2);
    en = 1'b1; jmp = 1'b1; jt = 32'h55;
    cyc(1'b0, 32'd2, 1'b0, 1'b1, 32'd2);
    stall = 1'b1;
    cyc(1'b0, 32'd2, 1'b0, 1'b1, 32'd2);
    stall = 1'b0; jmp = 1'b0;
    cyc(1'b0, 32'd2, 1'b0, 1'b1, 32'd2);
    do_reset(1'b0);

    wait_slot();
    wait_slot();
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
